// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: shared widths, JAL opcode and fetch FSM encoding (IF_JAL_PREDICT_EN users included)
package if_prefetch_pkg;
   localparam int P_ADDR_W = 32;
   localparam int P_INST_W = 32;
   localparam logic [6:0] OPC_JAL = 7'b1101111;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} state_t;
   function automatic logic is_jal(input logic [6:0] opc);
      return opc == OPC_JAL;
   endfunction
endpackage

// File: rtl/if_prefetch_if.sv
// if_prefetch_if: memory-side and IF/ID-side signals of the prefetching fetch stage
interface if_prefetch_if
   import if_prefetch_pkg::*;
#(
   parameter int ADDR_W = P_ADDR_W,
   parameter int INST_W = P_INST_W
);
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_gnt_i;
   logic              mem_busy_i;
   logic              mem_rvalid_i;
   logic [INST_W-1:0] mem_rdata_i;
   logic              flush_i;
   logic [ADDR_W-1:0] flush_pc_i;
   logic              inst_valid_o;
   logic [INST_W-1:0] inst_o;
   logic [ADDR_W-1:0] pc_o;
   logic              ifid_ready_i;
   logic              pred_taken_o;
   modport master (
      output mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o, pred_taken_o,
      input  mem_gnt_i, mem_busy_i, mem_rvalid_i, mem_rdata_i, flush_i, flush_pc_i, ifid_ready_i
   );
   modport slave (
      input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o, pred_taken_o,
      output mem_gnt_i, mem_busy_i, mem_rvalid_i, mem_rdata_i, flush_i, flush_pc_i, ifid_ready_i
   );
endinterface

// File: rtl/if_queue.sv
// if_queue: DEPTH-entry synchronous FIFO of fetched entries; clear beats push and pop
module if_queue #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_din,
   output logic [W-1:0]               o_head,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0]   r_count;
   logic          w_push, w_pop;
   assign w_pop  = i_pop && r_count != '0 && !i_clear;
   assign w_push = i_push && !i_clear && (r_count != (AW+1)'(DEPTH) || w_pop);
   // pointers wrap naturally; count tracks occupancy
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= r_wr + AW'(w_push);
         r_rd    <= r_rd + AW'(w_pop);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   // storage needs no reset; the head is masked while empty
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end
   assign o_head  = r_count != '0 ? r_mem[r_rd] : '0;
   assign o_count = r_count;
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: fetch FSM with one outstanding request feeding a prefetch queue; IF_JAL_PREDICT_EN adds JAL redirect
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int                ADDR_W   = P_ADDR_W,
   parameter int                INST_W   = P_INST_W,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic            clk,
   input logic            rst,
   if_prefetch_if.master  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
`ifdef IF_JAL_PREDICT_EN
   localparam int EW = ADDR_W + INST_W + 1;
`else
   localparam int EW = ADDR_W + INST_W;
`endif
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_fetch_pc, r_req_pc, w_next_pc;
   logic [CW-1:0]     w_count;
   logic [EW-1:0]     w_din, w_head;
   logic              w_space, w_push, w_pop, w_grant;
   // a slot is reserved for the in-flight response so a push never finds the queue full
   assign w_space = (w_count + CW'(r_state != S_IDLE)) < CW'(DEPTH);
   assign w_grant = r_state == S_IDLE && bus.mem_req_o && bus.mem_gnt_i;
   assign w_push  = r_state == S_WAIT && bus.mem_rvalid_i && !bus.flush_i;
   assign w_pop   = bus.inst_valid_o && bus.ifid_ready_i;
`ifdef IF_JAL_PREDICT_EN
   logic              w_jal;
   logic [ADDR_W-1:0] w_jimm;
   assign w_jal  = is_jal(bus.mem_rdata_i[6:0]);
   assign w_jimm = {{(ADDR_W-20){bus.mem_rdata_i[31]}}, bus.mem_rdata_i[19:12],
                    bus.mem_rdata_i[20], bus.mem_rdata_i[30:21], 1'b0};
   assign w_next_pc = r_req_pc + (w_jal ? w_jimm : ADDR_W'(4));
   assign w_din     = {r_req_pc, bus.mem_rdata_i, w_jal};
   assign {bus.pc_o, bus.inst_o, bus.pred_taken_o} = w_head;
`else
   assign w_next_pc = r_req_pc + ADDR_W'(4);
   assign w_din     = {r_req_pc, bus.mem_rdata_i};
   assign {bus.pc_o, bus.inst_o} = w_head;
   assign bus.pred_taken_o = 1'b0;
`endif
   if_queue #(.W(EW), .DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_clear (bus.flush_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_din),
      .o_head  (w_head),
      .o_count (w_count)
   );
   assign bus.inst_valid_o = w_count != '0;
   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   // next state: a response arriving during a flush is the in-flight one, so WAIT returns to IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_grant ? S_WAIT : S_IDLE;
         S_WAIT:  w_next = bus.mem_rvalid_i ? S_IDLE : (bus.flush_i ? S_DROP : S_WAIT);
         S_DROP:  w_next = bus.mem_rvalid_i ? S_IDLE : S_DROP;
         default: w_next = S_IDLE;
      endcase
   end
   // request outputs: only IDLE issues, never during reset, busy or flush
   always_comb begin
      bus.mem_req_o  = r_state == S_IDLE && !rst && !bus.mem_busy_i && w_space && !bus.flush_i;
      bus.mem_addr_o = rst ? '0 : r_fetch_pc;
   end
   // fetch PC follows flush first, then the accepted response
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= RESET_PC;
      end else begin
         if (w_grant) r_req_pc <= r_fetch_pc;
         if (bus.flush_i) r_fetch_pc <= bus.flush_pc_i;
         else if (w_push) r_fetch_pc <= w_next_pc;
      end
   end
endmodule
